// File: rtl/axil_core_bridge.sv
// axil_core_bridge: AXI4-Lite slave to in-order core bridge; define AXIL_BRIDGE_TIMEOUT_EN for the response watchdog.
module axil_core_bridge_fifo #(
  parameter int W = 1,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  localparam int A = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [A-1:0] rd_q, wr_q;
  logic [A:0] cnt_q;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (A+1)'(push_i) - (A+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
endmodule

module axil_core_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDR_WIDTH-1:0]             s_awaddr,
  input  logic                              s_awvalid,
  output logic                              s_awready,
  input  logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [DATA_WIDTH/8-1:0]           s_wstrb,
  input  logic                              s_wvalid,
  output logic                              s_wready,
  output logic [1:0]                        s_bresp,
  output logic                              s_bvalid,
  input  logic                              s_bready,
  input  logic [ADDR_WIDTH-1:0]             s_araddr,
  input  logic                              s_arvalid,
  output logic                              s_arready,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  output logic [1:0]                        s_rresp,
  output logic                              s_rvalid,
  input  logic                              s_rready,
  output logic                              core_req_valid,
  input  logic                              core_req_ready,
  output logic                              core_req_we,
  output logic [ADDR_WIDTH-1:0]             core_req_addr,
  output logic [DATA_WIDTH-1:0]             core_req_wdata,
  output logic [DATA_WIDTH/8-1:0]           core_req_wstrb,
  input  logic                              core_resp_valid,
  input  logic                              core_resp_is_write,
  input  logic [DATA_WIDTH-1:0]             core_resp_rdata,
  input  logic [1:0]                        core_resp_resp,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_mismatch
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = DATA_WIDTH / 8;
  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("axil_core_bridge: MAX_OUTSTANDING must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
  end
  logic aw_full_q, w_full_q, ar_full_q, last_wr_q, hold_q, hold_wr_q, err_q, err_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic [CW-1:0] credit_q, credit_d;
  logic wr_cand, rd_cand, grant_wr, issue, pop_r, pop_b;
  logic ord_head, ord_empty, ord_pop, resp_take, discard, tmo_fire, r_empty, b_empty;
  logic [DATA_WIDTH+1:0] r_din, r_head;
  logic [1:0] b_din, b_head;
  assign s_awready = !aw_full_q && !rst_n;
  assign s_wready = !w_full_q && !rst_n;
  assign s_arready = !ar_full_q && !rst_n;
  // A grant shown to the core stays put until accepted, even if a new tie appears.
  always_comb begin
    wr_cand = aw_full_q && w_full_q;
    rd_cand = ar_full_q;
    grant_wr = hold_q ? hold_wr_q : (wr_cand && rd_cand) ? !last_wr_q : wr_cand;
    core_req_valid = (wr_cand || rd_cand) && credit_q != CW'(MAX_OUTSTANDING);
    issue = core_req_valid && core_req_ready;
    pop_r = s_rvalid && s_rready;
    pop_b = s_bvalid && s_bready;
    resp_take = core_resp_valid && !discard && !ord_empty;
    ord_pop = resp_take || tmo_fire;
    r_din = tmo_fire ? {{DATA_WIDTH{1'b0}}, 2'b10} : {core_resp_rdata, core_resp_resp};
    b_din = tmo_fire ? 2'b10 : core_resp_resp;
    credit_d = credit_q + CW'(issue) - CW'(pop_r) - CW'(pop_b);
    err_d = core_resp_valid && !discard && (ord_empty || core_resp_is_write != ord_head);
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      last_wr_q <= 1'b1;
      hold_q <= 1'b0;
      hold_wr_q <= 1'b0;
      credit_q <= '0;
      err_q <= 1'b0;
    end else begin
      aw_full_q <= (s_awvalid && s_awready) || (aw_full_q && !(issue && grant_wr));
      w_full_q <= (s_wvalid && s_wready) || (w_full_q && !(issue && grant_wr));
      ar_full_q <= (s_arvalid && s_arready) || (ar_full_q && !(issue && !grant_wr));
      if (s_awvalid && s_awready) aw_addr_q <= s_awaddr;
      if (s_arvalid && s_arready) ar_addr_q <= s_araddr;
      if (s_wvalid && s_wready) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
      if (issue) last_wr_q <= grant_wr;
      hold_q <= core_req_valid && !core_req_ready;
      hold_wr_q <= grant_wr;
      credit_q <= credit_d;
      err_q <= err_d;
    end
  end
`ifdef AXIL_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic [CW-1:0] drop_q;
  // Responses owed for heads the watchdog already answered are swallowed.
  assign discard = core_resp_valid && drop_q != '0;
  assign tmo_fire = !ord_empty && !(core_resp_valid && !discard) && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tmo_q <= '0;
      drop_q <= '0;
    end else begin
      tmo_q <= (ord_pop || ord_empty) ? '0 : tmo_q + 1'b1;
      drop_q <= drop_q + CW'(tmo_fire) - CW'(discard);
    end
  end
`else
  assign discard = 1'b0;
  assign tmo_fire = 1'b0;
`endif
  axil_core_bridge_fifo #(.W(1), .D(MAX_OUTSTANDING)) u_ord (
    .clk(clk), .rst_n(rst_n), .push_i(issue), .din_i(grant_wr),
    .pop_i(ord_pop), .dout_o(ord_head), .empty_o(ord_empty)
  );
  axil_core_bridge_fifo #(.W(DATA_WIDTH + 2), .D(MAX_OUTSTANDING)) u_rfifo (
    .clk(clk), .rst_n(rst_n), .push_i(ord_pop && !ord_head), .din_i(r_din),
    .pop_i(pop_r), .dout_o(r_head), .empty_o(r_empty)
  );
  axil_core_bridge_fifo #(.W(2), .D(MAX_OUTSTANDING)) u_bfifo (
    .clk(clk), .rst_n(rst_n), .push_i(ord_pop && ord_head), .din_i(b_din),
    .pop_i(pop_b), .dout_o(b_head), .empty_o(b_empty)
  );
  assign s_rvalid = !r_empty;
  assign {s_rdata, s_rresp} = s_rvalid ? r_head : '0;
  assign s_bvalid = !b_empty;
  assign s_bresp = s_bvalid ? b_head : 2'b00;
  assign core_req_we = grant_wr;
  assign core_req_addr = grant_wr ? aw_addr_q : ar_addr_q;
  assign core_req_wdata = w_data_q;
  assign core_req_wstrb = w_strb_q;
  assign outstanding = credit_q;
  assign err_mismatch = err_q;
endmodule

// File: doc/axil_core_bridge.md
# axil_core_bridge

AXI4-Lite slave to single-port core request/response bridge, parametrised successor to the single-outstanding translator. Accepts AW/W/AR independently into one-entry skid buffers, arbitrates reads against writes round-robin, and keeps up to MAX_OUTSTANDING core transactions in flight with in-order response steering to the R and B channels. Sits between the AXI4-Lite interconnect and the direct-mapped cache core port.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; WSTRB width DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, power of two ≥2; max issued-but-unreturned plus buffered responses.
- TIMEOUT_CYCLES, 256, watchdog limit (used only with AXIL_BRIDGE_TIMEOUT_EN).

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  AXI write address.
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data.
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  AXI write response.
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  AXI read address.
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_WIDTH/2/1/1  AXI read data.
- core_req_valid  out 1; core_req_ready  in 1; core_req_we  out 1; core_req_addr  out ADDR_WIDTH; core_req_wdata  out DATA_WIDTH; core_req_wstrb  out DATA_WIDTH/8.
- core_resp_valid  in 1; core_resp_is_write  in 1; core_resp_rdata  in DATA_WIDTH; core_resp_resp  in 2. Core responses strictly in issue order, no backpressure.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current credit usage.
- err_mismatch  out  1  one-cycle pulse: core_resp_is_write disagrees with order FIFO head.

## Operation
- Skid buffers: AW, W, AR each one entry. s_awready/s_wready/s_arready = buffer empty, forced 0 while rst_n=1.
- Write candidate when AW and W buffers both full; read candidate when AR buffer full.
- Arbiter: round-robin, last_grant register reset to WRITE (read wins first tie). Only one candidate → it wins.
- Issue allowed when credits < MAX_OUTSTANDING. core_req_valid = winner exists && credit available; fields from winning buffer; held stable until core_req_ready. Grant locked while valid && !ready (no re-arbitration mid-handshake).
- On issue handshake: pop winning buffer(s), push type (we) into order FIFO (depth MAX_OUTSTANDING), credits +1, update last_grant.
- On core_resp_valid: pop order FIFO; type from FIFO (not core_resp_is_write) selects R FIFO {rdata,resp} or B FIFO {resp}; pulse err_mismatch if flags differ.
- R/B FIFOs depth MAX_OUTSTANDING; head drives s_rvalid/s_bvalid. Pop on valid&&ready; credits −1 on each pop. Credit scheme guarantees FIFOs never overflow.
- Simultaneous issue and AXI response pop: credits unchanged.
- core_resp_valid with order FIFO empty: ignored, err_mismatch pulses.

## Timing
- Reset (rst_n=1): all buffers/FIFOs empty, credits 0, all valid and ready outputs 0, s_bresp/s_rresp 2'b00, s_rdata 0, outstanding 0, err_mismatch 0. Reset mid-transaction discards all state; no responses emitted for lost transactions.
- AR accepted at edge N → core_req_valid high from cycle N+1 (earliest).
- AW and W accepted at N (or later of the two) → core_req_valid from N+1.
- core_resp_valid at edge M → s_rvalid/s_bvalid high from M+1; full throughput one response per cycle.
- Buffer refill: ready high the cycle after issue handshake pops it; accept-and-issue throughput one per 2 cycles per channel.
- AXI valid outputs never drop before ready (AXI rule).

## Configuration
- AXIL_BRIDGE_TIMEOUT_EN defined: counter tracks cycles since order FIFO head was issued; reaching TIMEOUT_CYCLES synthesises head's response with resp 2'b10 (SLVERR), rdata 0, pops order FIFO, increments drop counter; subsequent core responses decrement drop counter and are discarded. Counter resets on every order FIFO pop.
- Undefined: no watchdog, no drop counter; a silent core stalls the bridge indefinitely.

## Test plan
- Single read: AR 0x10, core_req_ready=1, core_resp rdata 0x12345678 resp 00 four cycles later -> one issue we=0 addr 0x10, s_rvalid next cycle with rdata 0x12345678, rresp 00.
- Split write: AW 0x20 at cycle 5, W 0xDEADBEEF strb 0xF at cycle 10 -> single issue we=1 at cycle 11, B resp 00 after core response.
- Contention: AR 0x40 and AW/W 0x44 same cycle -> read issued first, write next; subsequent tie -> write first.
- Credit limit: MAX_OUTSTANDING=4, core_req_ready=1, core never responds, s_rready=0 -> exactly 4 issues, core_req_valid stays 0, outstanding=4; after responses and R pops, issue resumes.
- Backpressure: s_bready=0 with 3 writes completed -> 3 B responses in order once s_bready=1, resps preserved.
- With AXIL_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16: read with no core response -> s_rvalid rresp 2'b10 at 16 cycles; late core response dropped, no extra R beat.
